// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
//
// Trap arbitration and sequencing for the 5-stage core. The block checks the
// memory-stage instruction for synchronous exceptions, checks the interrupt
// lines, and handles mret. It owns mepc, mcause, mtval and mstatus.MIE/MPIE.
// Trap entry takes two cycles. In the detect cycle the pipeline is flushed
// (combinationally) and the trap state is captured. In the next cycle the
// pipeline is flushed again and fetch is redirected.
//
// Optional build macro:
//   TRAP_IRQ_SYNC_EN  irq passes a 2-flop synchroniser (reset 0) before
//                     masking, which adds 2 cycles of interrupt latency.
//                     When the macro is undefined, irq is used the same cycle.
//
// Parameters:
//   XLEN     data/address width
//   NUM_IRQ  interrupt lines (1..16); line i reports cause code 16+i
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m_valid, m_pc             memory-stage instruction valid and its PC
//   m_misaligned/illegal/
//   m_ebreak/ecall            exception flags (codes 0, 2, 3, 11)
//   m_mret                    mret in the memory stage
//   m_tval                    trap value recorded for exceptions
//   irq, irq_mask             level interrupt lines and per-line enables
//   mtvec_base, mtvec_mode    trap base; mode 1 = vectored, others = direct
//   csr_mstatus_we,
//   csr_mie_wd, csr_mpie_wd   CSR write of MIE/MPIE
//   flush                     flush all pipeline latches
//   redirect, redirect_pc     fetch redirect request and target
//   mepc, mcause, mtval       trap CSRs
//   mstatus_mie/mpie          global interrupt enable and its previous value
//   busy                      FSM is not idle
// ---------------------------------------------------------------------------
module trap_controller #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_valid,
  input  logic [XLEN-1:0]    m_pc,
  input  logic               m_misaligned,
  input  logic               m_illegal,
  input  logic               m_ebreak,
  input  logic               m_ecall,
  input  logic               m_mret,
  input  logic [XLEN-1:0]    m_tval,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic [XLEN-1:0]    mtvec_base,
  input  logic [1:0]         mtvec_mode,
  input  logic               csr_mstatus_we,
  input  logic               csr_mie_wd,
  input  logic               csr_mpie_wd,
  output logic               flush,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    mepc,
  output logic [XLEN-1:0]    mtval,
  output logic [XLEN-1:0]    mcause,
  output logic               mstatus_mie,
  output logic               mstatus_mpie,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irq_sync;

`ifdef TRAP_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_meta;
  logic [NUM_IRQ-1:0] irq_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta   <= '0;
      irq_sync_q <= '0;
    end else begin
      irq_meta   <= irq;
      irq_sync_q <= irq_meta;
    end
  end

  assign irq_sync = irq_sync_q;
`else
  assign irq_sync = irq;
`endif

  logic            detect;
  logic            exc_any;
  logic [4:0]      exc_code;
  logic [NUM_IRQ-1:0] irq_pend;
  logic            irq_hit;
  logic [4:0]      irq_code;
  logic            take_exc;
  logic            take_irq;
  logic            take_mret;
  logic [4:0]      cause_code;
  logic [XLEN-1:0] trap_target;

  // NOTE: every signal written here gets a default first, so no latch can be
  // inferred when a branch leaves it unassigned.
  always_comb begin
    exc_code = 5'd0;
    if (m_misaligned)   exc_code = 5'd0;
    else if (m_illegal) exc_code = 5'd2;
    else if (m_ebreak)  exc_code = 5'd3;
    else if (m_ecall)   exc_code = 5'd11;
    exc_any = m_misaligned | m_illegal | m_ebreak | m_ecall;

    // Scan from the top down so that the lowest pending index is written last.
    irq_pend = irq_sync & irq_mask;
    irq_hit  = 1'b0;
    irq_code = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) begin
        irq_hit  = 1'b1;
        irq_code = 5'(16 + i);
      end
    end

    // Gating with rst keeps flush low while reset is held.
    detect    = !rst && (state == IDLE) && m_valid;
    take_exc  = detect && exc_any;
    take_irq  = detect && !exc_any && mstatus_mie && irq_hit;
    take_mret = detect && !exc_any && !take_irq && m_mret;

    cause_code  = take_exc ? exc_code : irq_code;
    trap_target = mtvec_base;
    if (take_irq && mtvec_mode == 2'd1)
      trap_target = mtvec_base + (XLEN'(cause_code) << 2);
  end

  assign flush = take_exc | take_irq | take_mret | (state != IDLE);
  assign busy  = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only. Reset is
  // asynchronous, so redirect and busy drop without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      mepc         <= '0;
      mtval        <= '0;
      mcause       <= '0;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          redirect <= 1'b0;
          if (take_exc || take_irq) begin
            mepc         <= m_pc;
            mcause       <= (XLEN'(take_irq) << (XLEN - 1)) | XLEN'(cause_code);
            mtval        <= take_exc ? m_tval : '0;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            redirect     <= 1'b1;
            redirect_pc  <= trap_target;
            state        <= ENTER;
          end else if (take_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            redirect     <= 1'b1;
            redirect_pc  <= mepc;
            state        <= RETURN;
          end else if (csr_mstatus_we) begin
            mstatus_mie  <= csr_mie_wd;
            mstatus_mpie <= csr_mpie_wd;
          end
        end
        ENTER, RETURN: begin
          redirect <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          redirect <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

  localparam int XLEN    = 32;
  localparam int NUM_IRQ = 4;
`ifdef TRAP_IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               m_valid, m_misaligned, m_illegal, m_ebreak, m_ecall, m_mret;
  logic [XLEN-1:0]    m_pc, m_tval, mtvec_base;
  logic [NUM_IRQ-1:0] irq, irq_mask;
  logic [1:0]         mtvec_mode;
  logic               csr_mstatus_we, csr_mie_wd, csr_mpie_wd;
  logic               flush, redirect, mstatus_mie, mstatus_mpie, busy;
  logic [XLEN-1:0]    redirect_pc, mepc, mtval, mcause;

  trap_controller #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_pc(m_pc), .m_misaligned(m_misaligned),
    .m_illegal(m_illegal), .m_ebreak(m_ebreak), .m_ecall(m_ecall),
    .m_mret(m_mret), .m_tval(m_tval), .irq(irq), .irq_mask(irq_mask),
    .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode),
    .csr_mstatus_we(csr_mstatus_we), .csr_mie_wd(csr_mie_wd),
    .csr_mpie_wd(csr_mpie_wd), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .mepc(mepc), .mtval(mtval), .mcause(mcause),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] tval;
    logic            mie;
    logic            mpie;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every redirect cycle must match the oldest expected trap or return.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && redirect) begin
      if (sb.size() == 0) begin
        check("unexpected_redirect", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_rpc"},   redirect_pc,  e.rpc);
        check({e.tag, "_cause"}, mcause,       e.cause);
        check({e.tag, "_mepc"},  mepc,         e.epc);
        check({e.tag, "_mtval"}, mtval,        e.tval);
        check({e.tag, "_mie"},   mstatus_mie,  e.mie);
        check({e.tag, "_mpie"},  mstatus_mpie, e.mpie);
        check({e.tag, "_flush2"}, flush,       1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    m_valid = 0; m_pc = '0; m_misaligned = 0; m_illegal = 0; m_ebreak = 0;
    m_ecall = 0; m_mret = 0; m_tval = '0;
    csr_mstatus_we = 0; csr_mie_wd = 0; csr_mpie_wd = 0;
  endtask

  // Inputs for the detect cycle are already driven; expect a trap or mret.
  task automatic take(input string tag, input logic [XLEN-1:0] rpc,
                      input logic [XLEN-1:0] cause, input logic [XLEN-1:0] epc,
                      input logic [XLEN-1:0] tval, input logic mie_e,
                      input logic mpie_e);
    #1;
    check({tag, "_flush"}, flush, 1);
    check({tag, "_idle"},  busy,  0);
    sb.push_back('{tag, rpc, cause, epc, tval, mie_e, mpie_e});
    tick();
    clear_ev();
    check({tag, "_busy"}, busy, 1);
    tick();
    check({tag, "_done"}, busy, 0);
    check({tag, "_redir_off"}, redirect, 0);
  endtask

  // Inputs are already driven; expect no event.
  task automatic no_take(input string tag);
    #1;
    check({tag, "_noflush"}, flush, 0);
    tick();
    check({tag, "_nobusy"}, busy, 0);
    clear_ev();
  endtask

  task automatic csr_write(input logic mie_v, input logic mpie_v);
    csr_mstatus_we = 1; csr_mie_wd = mie_v; csr_mpie_wd = mpie_v;
    tick();
    clear_ev();
    check("csr_mie", mstatus_mie, mie_v);
    check("csr_mpie", mstatus_mpie, mpie_v);
  endtask

  initial begin
    rst = 1;
    clear_ev();
    irq = '0; irq_mask = 4'hF; mtvec_base = 32'h800; mtvec_mode = 2'd0;
    #12;
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect, 0);
    check("rst_busy", busy, 0);
    check("rst_mepc", mepc, 0);
    check("rst_mcause", mcause, 0);
    check("rst_mtval", mtval, 0);
    check("rst_mie", mstatus_mie, 0);
    check("rst_mpie", mstatus_mpie, 0);
    check("rst_rpc", redirect_pc, 0);
    rst = 0;
    tick();

    // Illegal instruction; a simultaneous CSR write is overridden.
    m_valid = 1; m_pc = 32'h100; m_illegal = 1; m_tval = 32'hDEAD;
    csr_mstatus_we = 1; csr_mie_wd = 1; csr_mpie_wd = 1;
    take("illegal", 32'h800, 32'd2, 32'h100, 32'hDEAD, 0, 0);

    // mret together with ebreak: the exception wins.
    m_valid = 1; m_pc = 32'h108; m_ebreak = 1; m_mret = 1; m_tval = 32'h77;
    take("ebreak_mret", 32'h800, 32'd3, 32'h108, 32'h77, 0, 0);

    // Exception flags without m_valid are ignored.
    m_illegal = 1; m_pc = 32'h10C;
    no_take("invalid");

    // Pending irq with MIE=0 is not taken.
    irq = 4'b0001;
    for (int i = 0; i < SYNC_LAT; i++) tick();
    m_valid = 1; m_pc = 32'h120;
    no_take("mie_off");

    csr_write(1, 0);

    // MIE=1 but the line is masked.
    irq_mask = 4'b0000;
    m_valid = 1; m_pc = 32'h124;
    no_take("masked");
    irq_mask = 4'hF;

    // Priority: illegal beats ecall and irq[0]; vectored mode is not used.
    mtvec_mode = 2'd1;
    m_valid = 1; m_pc = 32'h300; m_ecall = 1; m_illegal = 1; m_tval = 32'h55;
    take("priority", 32'h800, 32'd2, 32'h300, 32'h55, 0, 1);

    // irq[0] is still pending but blocked until mret.
    for (int i = 0; i < 2; i++) begin
      m_valid = 1; m_pc = 32'h304;
      no_take("blocked");
    end

    m_valid = 1; m_pc = 32'h30C; m_mret = 1;
    take("mret1", 32'h300, 32'd2, 32'h300, 32'h55, 1, 1);

    // The pending irq[0] is retaken on the next valid cycle.
    m_valid = 1; m_pc = 32'h310;
    take("retake0", 32'h840, 32'h8000_0010, 32'h310, 32'h0, 0, 1);

    // Vectored interrupt on line 2, including the synchroniser latency.
    irq = '0;
    for (int i = 0; i < SYNC_LAT + 1; i++) tick();
    csr_write(1, 0);
    irq = 4'b0100;
    m_valid = 1; m_pc = 32'h200;
    for (int i = 0; i < SYNC_LAT; i++) begin
      #1;
      check("sync_lat", flush, 0);
      tick();
    end
    take("vec_irq2", 32'h848, 32'h8000_0012, 32'h200, 32'h0, 0, 1);

    m_valid = 1; m_pc = 32'h204; m_mret = 1;
    take("mret2", 32'h200, 32'h8000_0012, 32'h200, 32'h0, 1, 1);

    // Lowest pending index wins; m_tval is ignored for interrupts.
    irq = 4'b1100;
    m_valid = 1; m_pc = 32'h208; m_tval = 32'h1234;
    take("retake2", 32'h848, 32'h8000_0012, 32'h208, 32'h0, 0, 1);

    // Mode 2 behaves as direct.
    csr_write(1, 0);
    mtvec_mode = 2'd2;
    m_valid = 1; m_pc = 32'h210;
    take("mode2", 32'h800, 32'h8000_0012, 32'h210, 32'h0, 0, 1);

    // Vectored target wraps modulo 2^XLEN.
    csr_write(1, 0);
    mtvec_mode = 2'd1; mtvec_base = 32'hFFFF_FFF0;
    m_valid = 1; m_pc = 32'h220;
    take("wrap", 32'h0000_0038, 32'h8000_0012, 32'h220, 32'h0, 0, 1);
    mtvec_base = 32'h800;

    // Misaligned has the highest priority.
    m_valid = 1; m_pc = 32'h400; m_misaligned = 1; m_illegal = 1;
    m_ebreak = 1; m_ecall = 1; m_tval = 32'h402;
    take("misaligned", 32'h800, 32'd0, 32'h400, 32'h402, 0, 0);

    // Reset while in ENTER drops everything without a clock edge.
    m_valid = 1; m_pc = 32'h500; m_illegal = 1; m_tval = 32'h9;
    tick();
    clear_ev();
    check("enter_redirect", redirect, 1);
    #1 rst = 1;
    #1;
    check("rst_enter_redirect", redirect, 0);
    check("rst_enter_flush", flush, 0);
    check("rst_enter_busy", busy, 0);
    check("rst_enter_mcause", mcause, 0);
    #1 rst = 0;
    tick();
    check("post_rst_busy", busy, 0);

    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
